// File: rtl/common_pkg.sv
// Shared instruction-bus types and the default SRAM latency.
package common;

  localparam int MEM_LATENCY_DFLT = 2;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

endpackage

// File: rtl/pipes_pkg.sv
// Pipeline-side state types; S_PREF is only reachable with IBUS_PREFETCH_EN.
package pipes;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_DRAIN,
    S_PREF
  } ibus_resp_state_t;

endpackage

// File: rtl/ibus_prefetch_buf.sv
// One-entry {tag, data, valid} buffer holding the sequentially prefetched word.
module ibus_prefetch_buf (
  input  logic        clk,
  input  logic        resetn,
  input  logic        fill,
  input  logic [31:0] fill_tag,
  input  logic [31:0] fill_data,
  input  logic        inval,
  input  logic [31:0] lkp_addr,
  output logic        hit,
  output logic [31:0] hit_data
);

  logic        valid_q, valid_d;
  logic [31:0] tag_q, tag_d;
  logic [31:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (inval) valid_d = 1'b0;
    if (fill) begin
      valid_d = 1'b1;
      tag_d   = fill_tag;
      data_d  = fill_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit      = valid_q && (tag_q == lkp_addr);
  assign hit_data = data_q;

endmodule

// File: rtl/ibus_responder.sv
// Instruction-bus responder: one outstanding fixed-latency SRAM read, cancel-tolerant.
// Define IBUS_PREFETCH_EN to add the one-entry sequential prefetch buffer.
module ibus_responder
  import common::*;
  import pipes::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DFLT,
  parameter int MEM_AW      = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  ibus_req_t         ireq,
  output ibus_resp_t        iresp,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              misalign
);

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  ibus_resp_state_t state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic             data_ok_q, data_ok_d;
  logic             addr_ok;
  logic             mem_done, req_mis;

  assign mem_done = (cnt_q == LAT);
  assign req_mis  = (ireq.addr[1:0] != 2'b00);

`ifdef IBUS_PREFETCH_EN
  logic        arm_q, arm_d;
  logic        pf_fill, pf_inval, pf_hit;
  logic [31:0] pf_data, pf_next;

  assign pf_next = addr_q + 32'd4;

  ibus_prefetch_buf u_pf (
    .clk      (clk),
    .resetn   (resetn),
    .fill     (pf_fill),
    .fill_tag (addr_q),
    .fill_data(mem_rdata),
    .inval    (pf_inval),
    .lkp_addr (ireq.addr),
    .hit      (pf_hit),
    .hit_data (pf_data)
  );
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = mem_done ? 4'd0 : cnt_q + 4'd1;
    addr_d   = addr_q;
    data_d   = data_q;
    addr_ok  = 1'b0;
    mem_en   = 1'b0;
    mem_addr = addr_q[MEM_AW+1:2];
    misalign = 1'b0;
`ifdef IBUS_PREFETCH_EN
    arm_d    = arm_q;
    pf_fill  = 1'b0;
    pf_inval = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = cnt_q;
`ifdef IBUS_PREFETCH_EN
        arm_d = 1'b0;
`endif
        if (ireq.valid) begin
          addr_ok = 1'b1;
          addr_d  = ireq.addr;
          if (req_mis) begin
            misalign = 1'b1;
            data_d   = '0;
            state_d  = S_RESP;
`ifdef IBUS_PREFETCH_EN
          end else if (pf_hit) begin
            data_d  = pf_data;
            arm_d   = 1'b1;
            state_d = S_RESP;
`endif
          end else begin
            mem_en   = 1'b1;
            mem_addr = ireq.addr[MEM_AW+1:2];
            cnt_d    = 4'd1;
            state_d  = S_WAIT;
`ifdef IBUS_PREFETCH_EN
            pf_inval = 1'b1;
`endif
          end
`ifdef IBUS_PREFETCH_EN
        end else if (arm_q) begin
          mem_en   = 1'b1;
          mem_addr = pf_next[MEM_AW+1:2];
          addr_d   = pf_next;
          cnt_d    = 4'd1;
          state_d  = S_PREF;
`endif
        end
      end
      S_WAIT: begin
        // A withdrawn or redirected request abandons the read; data landing this cycle is dropped too.
        if (!ireq.valid || ireq.addr != addr_q) begin
          state_d = mem_done ? S_IDLE : S_DRAIN;
        end else if (mem_done) begin
          data_d  = mem_rdata;
          state_d = S_RESP;
`ifdef IBUS_PREFETCH_EN
          arm_d   = 1'b1;
`endif
        end
      end
      S_RESP: begin
        cnt_d   = cnt_q;
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (mem_done) state_d = S_IDLE;
      end
`ifdef IBUS_PREFETCH_EN
      S_PREF: begin
        pf_fill = mem_done;
        // A demand for the word in flight rides the prefetch instead of reissuing it.
        if (ireq.valid && ireq.addr == addr_q) begin
          addr_ok = 1'b1;
          if (mem_done) begin
            data_d  = mem_rdata;
            arm_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end else if (mem_done) begin
          state_d = S_IDLE;
        end
      end
`endif
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    data_ok_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      data_ok_q <= 1'b0;
`ifdef IBUS_PREFETCH_EN
      arm_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      data_ok_q <= data_ok_d;
`ifdef IBUS_PREFETCH_EN
      arm_q     <= arm_d;
`endif
    end
  end

  assign iresp = {addr_ok, data_ok_q, data_q};

endmodule

// File: tb/tb_ibus_responder.sv
// Directed plus randomized bench for ibus_responder against a per-transaction timing model.
module tb_ibus_responder;
  import common::*;

  localparam int L  = 2;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  ibus_req_t     ireq;
  ibus_resp_t    iresp;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic          misalign;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ibus_responder #(.MEM_LATENCY(L), .MEM_AW(AW)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .ireq     (ireq),
    .iresp    (iresp),
    .mem_en   (mem_en),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .misalign (misalign)
  );

  // SRAM model: contents are a fixed function of the word address, returned L cycles after mem_en.
  function automatic logic [31:0] word(input logic [AW-1:0] a);
    return (a == '0) ? 32'h0000_0013 : {~a, a ^ 16'h5A3C};
  endfunction

  logic          pe [1:L];
  logic [AW-1:0] pa [1:L];
  initial for (int i = 1; i <= L; i++) begin pe[i] = 1'b0; pa[i] = '0; end

  always @(posedge clk) begin
    pe[1] <= mem_en;
    pa[1] <= mem_addr;
    for (int i = 2; i <= L; i++) begin
      pe[i] <= pe[i-1];
      pa[i] <= pa[i-1];
    end
  end
  assign mem_rdata = pe[L] ? word(pa[L]) : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request: accept in cycle 0, data_ok in cycle L+1, unless cancelled in cycle ck (1..L).
  task automatic txn(input logic [31:0] a, input int ck, input bit chg, input logic [31:0] na);
    bit m;
    m = (a[1:0] != 2'b00);
    ireq.valid = 1'b1;
    ireq.addr  = a;
    @(negedge clk);
    chk("acc.addr_ok", 32'(iresp.addr_ok), 32'd1);
    chk("acc.misalign", 32'(misalign), 32'(m));
    chk("acc.mem_en", 32'(mem_en), 32'(!m));
    chk("acc.data_ok", 32'(iresp.data_ok), 32'd0);
    if (!m) chk("acc.mem_addr", 32'(mem_addr), 32'(a[AW+1:2]));
    tick();
    if (m) begin
      ireq.valid = 1'b0;
      @(negedge clk);
      chk("mis.data_ok", 32'(iresp.data_ok), 32'd1);
      chk("mis.data", iresp.data, 32'd0);
      chk("mis.mem_en", 32'(mem_en), 32'd0);
      tick();
      return;
    end
    for (int c = 1; c <= L; c++) begin
      if (ck != 0 && c == ck) begin
        if (chg) ireq.addr = na;
        else     ireq.valid = 1'b0;
      end
      @(negedge clk);
      chk("busy.addr_ok", 32'(iresp.addr_ok), 32'd0);
      chk("busy.data_ok", 32'(iresp.data_ok), 32'd0);
      chk("busy.mem_en", 32'(mem_en), 32'd0);
      tick();
    end
    if (ck == 0) begin
      ireq.valid = 1'b0;
      @(negedge clk);
      chk("resp.data_ok", 32'(iresp.data_ok), 32'd1);
      chk("resp.data", iresp.data, word(a[AW+1:2]));
      tick();
    end else if (!chg) begin
      @(negedge clk);
      chk("drain.no_data_ok", 32'(iresp.data_ok), 32'd0);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, na;
    int mode, k;
    ireq = '0;
    #2;
    chk("rst.iresp", 32'(iresp), 32'd0);
    chk("rst.mem_en", 32'(mem_en), 32'd0);
    chk("rst.misalign", 32'(misalign), 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    txn(32'h8000_0000, 0, 1'b0, 32'h0);
    txn(32'h8000_0008, 1, 1'b0, 32'h0);
    txn(32'h8000_0010, 0, 1'b0, 32'h0);
    txn(32'h8000_0004, L, 1'b1, 32'h8000_0100);
    txn(32'h8000_0100, 0, 1'b0, 32'h0);
    txn(32'h8000_0002, 0, 1'b0, 32'h0);

    // Reset while a read is outstanding.
    ireq.valid = 1'b1;
    ireq.addr  = 32'h8000_0020;
    tick();
    #2;
    resetn = 1'b0;
    ireq.valid = 1'b0;
    #1;
    chk("rstw.iresp", 32'(iresp), 32'd0);
    chk("rstw.mem_en", 32'(mem_en), 32'd0);
    chk("rstw.misalign", 32'(misalign), 32'd0);
    tick();
    tick();
    resetn = 1'b1;
    for (int c = 0; c < L + 1; c++) begin
      @(negedge clk);
      chk("rstw.no_stale", 32'(iresp.data_ok), 32'd0);
      tick();
    end
    txn(32'h8000_0024, 0, 1'b0, 32'h0);

    for (int t = 0; t < 40; t++) begin
      a    = 32'h8000_0000 | ($urandom & 32'h0003_FFFC);
      mode = $urandom_range(0, 5);
      k    = $urandom_range(1, L);
      if (mode == 0) txn(a | 32'($urandom_range(1, 3)), 0, 1'b0, 32'h0);
      else if (mode == 1) txn(a, k, 1'b0, 32'h0);
      else if (mode == 2) begin
        na = a ^ 32'h0000_0100;
        txn(a, k, 1'b1, na);
        txn(na, 0, 1'b0, 32'h0);
      end else txn(a, 0, 1'b0, 32'h0);
    end

`ifdef IBUS_PREFETCH_EN
    txn(32'h8000_0000, 0, 1'b0, 32'h0);
    @(negedge clk);
    chk("pf.issue_en", 32'(mem_en), 32'd1);
    chk("pf.issue_addr", 32'(mem_addr), 32'd1);
    tick();
    tick();
    tick();
    ireq.valid = 1'b1;
    ireq.addr  = 32'h8000_0004;
    @(negedge clk);
    chk("pf.hit_addr_ok", 32'(iresp.addr_ok), 32'd1);
    chk("pf.hit_mem_en", 32'(mem_en), 32'd0);
    tick();
    ireq.valid = 1'b0;
    @(negedge clk);
    chk("pf.hit_data_ok", 32'(iresp.data_ok), 32'd1);
    chk("pf.hit_data", iresp.data, word(16'd1));
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ibus_responder.md
# ibus_responder

Memory-side responder for the instruction bus: accepts `ibus_req_t` requests from the fetch stage, issues single-word reads to a fixed-latency pipelined instruction SRAM, and returns the instruction word with `ibus_resp_t` handshakes. It sits between fetch and the instruction memory (or its simulation model). It tolerates requests that are withdrawn or changed mid-flight, as happens on stalls and redirects. An optional one-entry sequential prefetch buffer cuts sequential-fetch latency.

## Interface
- `MEM_LATENCY`, 2: cycles from `mem_en` to valid `mem_rdata`; legal 1..15.
- `MEM_AW`, 16: SRAM word-address width.

- `clk`  in  1  clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ireq`  in  `ibus_req_t`  request; only `valid` and `addr` are used.
- `iresp`  out  `ibus_resp_t`  `addr_ok`, `data_ok`, `data` (u32).
- `mem_en`  out  1  SRAM read strobe; one read per asserted cycle.
- `mem_addr`  out  `MEM_AW`  word address, equal to `addr[MEM_AW+1:2]`.
- `mem_rdata`  in  32  read data, valid exactly `MEM_LATENCY` cycles after its `mem_en`.
- `misalign`  out  1  one-cycle pulse when a request has `addr[1:0] != 0`.

## Operation
- States: IDLE, WAIT, RESP, DRAIN (plus PREF when prefetch is configured).
- At most one SRAM read is outstanding. A 4-bit counter tracks it.
- **IDLE**, `ireq.valid=1`:
  - `addr_ok=1` combinationally.
  - `addr` is latched, `mem_en=1`, and the state moves to WAIT.
- **Misaligned request:**
  - No SRAM read is issued. `addr_ok=1` and `misalign=1` in the same cycle.
  - Next cycle goes to RESP with `data=32'h0`.
- **WAIT:**
  - The counter runs to `MEM_LATENCY`. `mem_rdata` is captured into the data register.
  - Next state is RESP.
- **RESP:**
  - `data_ok=1` for exactly one cycle, with `data` from the register. Then IDLE.
- **Cancel:**
  - Trigger: in WAIT, `ireq.valid=0` or `ireq.addr` differs from the latched address.
  - The state moves to DRAIN. The read completes, its data is discarded and no `data_ok` is issued, then IDLE.
  - A cancel in the same cycle the data returns also discards it.
- New requests are not accepted in WAIT, RESP or DRAIN (`addr_ok=0`). The requester holds `valid` until `addr_ok`.
- **Reset:**
  - State IDLE, counter 0, data register 0, prefetch buffer invalid.
  - `addr_ok`, `data_ok`, `mem_en` and `misalign` are all 0, `data=0`.
  - Reset mid-read drops the read silently.

## Timing
- Miss latency: request accepted in cycle 0, `data_ok` in cycle `MEM_LATENCY+1`.
- Back-to-back: the next request can be accepted in the cycle after `data_ok`. Sustained throughput is one word per `MEM_LATENCY+2` cycles without prefetch.
- `addr_ok` is combinational from `ireq.valid` and the state. `data_ok` and `data` are registered.
- `data_ok` is never asserted for a cancelled or drained transaction.

## Configuration
- `IBUS_PREFETCH_EN` defined:
  - After each RESP for aligned address A, if `ireq.valid=0` in IDLE, a read of A+4 is issued (state PREF).
  - The returned word fills a one-entry buffer {tag, data, valid}.
  - **Hit:** an IDLE request whose addr equals a valid tag gets `addr_ok` in cycle 0 and `data_ok` in cycle 1, with no SRAM read.
  - **Request during PREF** with addr A+4: it attaches to the in-flight read and takes `data_ok` one cycle after the data returns.
  - **Request during PREF** with any other addr: it waits for the prefetch to land (`addr_ok=0`), then is served as a miss.
  - Any demand miss invalidates the buffer.
- Undefined: no PREF state and no buffer. Every request is a miss.

## Structure
- Add `ibus_resp_state_t` (state enum) to package `pipes`.
- Add the `MEM_LATENCY` default as a localparam in `common`.
- `ibus_req_t` and `ibus_resp_t` are reused from `common`.
- One sub-module, `ibus_prefetch_buf`: tag/data/valid register with a hit compare, instantiated only under the macro.

## Test plan
- Reset with `MEM_LATENCY=2`, request addr `0x8000_0000`, SRAM word `0x0000_0013`:
  - `addr_ok` in cycle 0, `mem_addr=0`, `data_ok` in cycle 3 with `data=0x0000_0013`, all outputs 0 before.
- Request at `0x8000_0008`, then drop `valid` in cycle 1:
  - No `data_ok`. A new request at `0x8000_0010` is refused until DRAIN ends, then served with `mem_addr=4`.
- Request at `0x8000_0004`, change addr to `0x8000_0100` in the data-return cycle:
  - The old data is discarded and the new addr is served later with correct data.
- Request at `0x8000_0002`:
  - `misalign` pulse in cycle 0, `data_ok` in cycle 1 with `data=0`, no `mem_en`.
- With `IBUS_PREFETCH_EN`, sequential requests at `0x8000_0000`, then `0x8000_0004` after an idle gap of at least `MEM_LATENCY+1` cycles:
  - The second request gets `data_ok` one cycle after acceptance, with no `mem_en` that cycle.
- Assert `resetn=0` in WAIT:
  - Outputs go to 0 immediately. After release, a fresh request completes normally and no stale `data_ok` appears.
